// File: rtl/seg_scan_driver.sv
// Time-multiplexed driver for a common-anode multi-digit seven-segment display.
// Latches a whole frame of digit patterns at once and leaves a blank gap before each digit.
module seg_scan_driver #(
  parameter int NUM_DIGITS   = 2,
  parameter int SCAN_DIV     = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [8*NUM_DIGITS-1:0] seg_in,
  output logic [7:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    frame_start
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    ON    = 2'd2
  } state_t;

  state_t                  state_reg, state_next;
  logic [CNT_W-1:0]        cnt_reg, cnt_next;
  logic [IDX_W-1:0]        idx_reg, idx_next;
  logic [8*NUM_DIGITS-1:0] snap_reg;
  logic                    snap_load;

  logic [7:0]              seg_out_reg, seg_out_next;
  logic [NUM_DIGITS-1:0]   digit_sel_reg, digit_sel_next;
  logic                    frame_start_reg, frame_start_next;

  logic [7:0]              snap_byte [NUM_DIGITS];

  // Outputs are decoded from the next state so they line up with the state they describe.
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign snap_byte[gi]      = snap_reg[8*gi +: 8];
      assign digit_sel_next[gi] = !((state_next == ON) && (idx_next == IDX_W'(gi)));
    end
  endgenerate

  always_comb begin
    state_next       = state_reg;
    cnt_next         = cnt_reg;
    idx_next         = idx_reg;
    snap_load        = 1'b0;
    frame_start_next = 1'b0;

    case (state_reg)
      IDLE: begin
        if (en) begin
          state_next       = BLANK;
          cnt_next         = '0;
          idx_next         = '0;
          snap_load        = 1'b1;
          frame_start_next = 1'b1;
        end
      end

      BLANK: begin
        if (!en) begin
          state_next = IDLE;
          cnt_next   = '0;
          idx_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
          if (cnt_reg == BLANK_LAST) begin
            state_next = ON;
          end
        end
      end

      ON: begin
        if (!en) begin
          state_next = IDLE;
          cnt_next   = '0;
          idx_next   = '0;
        end else if (cnt_reg == SLOT_LAST) begin
          state_next = BLANK;
          cnt_next   = '0;
          // Wrapping back to digit 0 is the frame boundary: take a fresh snapshot.
          if (idx_reg == IDX_LAST) begin
            idx_next         = '0;
            snap_load        = 1'b1;
            frame_start_next = 1'b1;
          end else begin
            idx_next = idx_reg + IDX_W'(1);
          end
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      default: begin
        state_next = IDLE;
        cnt_next   = '0;
        idx_next   = '0;
      end
    endcase
  end

  // Snapshot only changes on BLANK entry, so the registered copy is valid for ON.
  always_comb begin
    seg_out_next = 8'hFF;
    if (state_next == ON) begin
      seg_out_next = snap_byte[idx_next];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      idx_reg         <= '0;
      snap_reg        <= '1;
      seg_out_reg     <= 8'hFF;
      digit_sel_reg   <= '1;
      frame_start_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      idx_reg         <= idx_next;
      seg_out_reg     <= seg_out_next;
      digit_sel_reg   <= digit_sel_next;
      frame_start_reg <= frame_start_next;
      if (snap_load) begin
        snap_reg <= seg_in;
      end
    end
  end

  assign seg_out     = seg_out_reg;
  assign digit_sel   = digit_sel_reg;
  assign frame_start = frame_start_reg;

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Sits directly downstream of the LFSR/hex-decoder top. Consumes its packed seven-segment bus (one active-low byte per digit) and drives a physical common-anode multi-digit display by time-multiplexing.
- Frame-synchronous snapshot of the input prevents tearing. A blanking gap between digits prevents ghosting.
- Gives a single-digit-select board interface in place of static per-digit segment wiring.

Parameters:
- NUM_DIGITS, 2, number of digits scanned (>= 1).
- SCAN_DIV, 100000, clk cycles per digit slot (blank + on); must satisfy SCAN_DIV > BLANK_CYCLES.
- BLANK_CYCLES, 16, cycles at the start of each slot with all digits off (>= 1).

Ports:
- clk  input  1  system clock, all logic rising-edge.
- rst_n  input  1  reset; synchronous, active-low.
- en  input  1  scan enable; 0 turns the display fully off.
- seg_in  input  8*NUM_DIGITS  packed patterns, digit i = seg_in[8i+7:8i], active-low, passed through bit-exact.
- seg_out  output  8  active-low segment pattern of the currently lit digit.
- digit_sel  output  NUM_DIGITS  active-low one-hot digit enable.
- frame_start  output  1  one-cycle pulse when a new frame snapshot is taken.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, idx=0, cnt=0, snap=all 1s.
  - seg_out=8'hFF, digit_sel=all 1s, frame_start=0.
  - Reset wins over every other event.
- All outputs are registered. No combinational path from any input to any output.
- State IDLE:
  - Outputs are the off values; frame_start=0.
  - If en=1, next state is BLANK with idx=0 and cnt=0.
  - On that same transition: snap<=seg_in and frame_start<=1.
- State BLANK:
  - digit_sel=all 1s, seg_out=8'hFF.
  - cnt counts 0..BLANK_CYCLES-1.
  - At cnt==BLANK_CYCLES-1, go to ON.
- State ON:
  - digit_sel[idx]=0 (others 1), seg_out=snap[idx].
  - Lasts SCAN_DIV-BLANK_CYCLES cycles, with cnt continuing to SCAN_DIV-1.
  - At cnt==SCAN_DIV-1: cnt<=0 and go to BLANK.
  - idx<=idx+1, wrapping from NUM_DIGITS-1 to 0.
  - On the wrap only: snap<=seg_in and frame_start<=1 on the BLANK-entry cycle.
- Timing:
  - Frame period is exactly NUM_DIGITS*SCAN_DIV cycles.
  - frame_start is high for exactly 1 cycle per frame, coincident with the first BLANK cycle of digit 0.
- Snapshot semantics: seg_in changes during a frame are invisible until the next frame.
- en=0 sampled in BLANK or ON: the next cycle is IDLE, with outputs off and idx/cnt cleared. The current slot is abandoned.
- en=1 re-assertion always restarts at digit 0 with a fresh snapshot and a frame_start pulse.
- Simultaneous end-of-slot and en=0: en wins, go to IDLE.
- Widths:
  - cnt is $clog2(SCAN_DIV) bits.
  - idx is $clog2(NUM_DIGITS) bits, minimum 1.
  - NUM_DIGITS=1: idx is always 0, and every slot is a frame (frame_start every SCAN_DIV cycles).
- Never more than one digit_sel bit low in any cycle. digit_sel is never low during BLANK.

Test Plan:
- Reset: rst_n=0 for 3 cycles with en=1, seg_in=16'h0000 -> digit_sel=2'b11, seg_out=8'hFF, frame_start=0 throughout.
- Basic scan (SCAN_DIV=8, BLANK_CYCLES=2, seg_in=16'hC0F9, en=1 after reset), cycles numbered from the first BLANK cycle:
  - Cycle 0: frame_start=1; cycles 0-1: off.
  - Cycles 2-7: digit_sel=2'b10, seg_out=8'hF9.
  - Cycles 8-9: off.
  - Cycles 10-15: digit_sel=2'b01, seg_out=8'hC0.
  - Next frame_start at cycle 16.
- Snapshot (same params): change seg_in to 16'hA4B0 at cycle 5 -> seg_out stays F9/C0 for the rest of the frame; B0/A4 appear from cycle 18/26.
- Enable drop: en=0 at cycle 11 -> from the next cycle digit_sel=2'b11, seg_out=8'hFF. en=1 later -> frame_start=1 and digit 0 lit after 2 blank cycles.
- Mid-operation reset: rst_n=0 for 1 cycle during ON of digit 1 -> next cycle off and IDLE; after release, scan restarts at digit 0.
- Wrap (NUM_DIGITS=4, SCAN_DIV=4, BLANK_CYCLES=1, seg_in=32'h99B0A4F9):
  - digit_sel sequence is 1110, 1101, 1011, 0111, then back to 1110.
  - frame_start every 16 cycles; checker asserts at most one digit_sel bit low every cycle.
